universal_shift_register: RTL and testbench

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

---
 rtl/shift_pkg.sv | 28 ++
 rtl/usr_step.sv | 29 ++
 rtl/universal_shift_register.sv | 96 +++++++++
 tb/tb_universal_shift_register.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: operation modes and
// burst-control FSM states.
package shift_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_LOAD  = 3'b001,
      MODE_SHL   = 3'b010,
      MODE_SHR   = 3'b011,
      MODE_ROL   = 3'b100,
      MODE_ROR   = 3'b101,
      MODE_ASR   = 3'b110,
      MODE_CLEAR = 3'b111
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Only the shift/rotate family can run as a multi-step burst.
   function automatic logic is_burst_mode(input mode_t m);
      return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
             (m == MODE_ROR) || (m == MODE_ASR);
   endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-step next-value logic for the universal shift register.
// LOAD has no data input here; the top overrides the result with d.
module usr_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  mode_t            mode,
   input  logic             serial_in,
   output logic [WIDTH-1:0] next_q
);

   always_comb begin
      next_q = q;
      case (mode)
         MODE_HOLD:  next_q = q;
         MODE_LOAD:  next_q = q;
         MODE_SHL:   next_q = {q[WIDTH-2:0], serial_in};
         MODE_SHR:   next_q = {serial_in, q[WIDTH-1:1]};
         MODE_ROL:   next_q = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROR:   next_q = {q[0], q[WIDTH-1:1]};
         MODE_ASR:   next_q = {q[WIDTH-1], q[WIDTH-1:1]};
         MODE_CLEAR: next_q = '0;
         default:    next_q = q;
      endcase
   end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with single-step operations and counted bursts
// of shift/rotate steps, signalled by busy and a one-cycle done pulse.
module universal_shift_register
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             serial_in,
   input  logic             start,
   input  logic [CNT_W-1:0] amount,
   output logic [WIDTH-1:0] q,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state, next_state;
   mode_t            burst_mode, next_burst_mode;
   mode_t            mode_in, step_mode;
   logic [CNT_W-1:0] count, next_count;
   logic [WIDTH-1:0] step_q, next_q;

   assign mode_in   = mode_t'(mode);
   assign step_mode = (state == ST_BUSY) ? burst_mode : mode_in;

   usr_step #(.WIDTH(WIDTH)) u_step (
      .q         (q),
      .mode      (step_mode),
      .serial_in (serial_in),
      .next_q    (step_q)
   );

   assign serial_out = ((step_mode == MODE_SHL) || (step_mode == MODE_ROL)) ?
                       q[WIDTH-1] : q[0];

   always_comb begin
      next_state      = state;
      next_q          = q;
      next_count      = count;
      next_burst_mode = burst_mode;
      case (state)
         ST_BUSY: begin
            next_q     = step_q;
            next_count = count - ONE;
            if (count <= ONE) begin
               next_count = '0;
               next_state = ST_DONE;
            end
         end
         default: begin
            // IDLE and DONE accept a new operation identically.
            if (start && is_burst_mode(mode_in)) begin
               next_burst_mode = mode_in;
               if (amount == '0) begin
                  next_count = '0;
                  next_state = ST_DONE;
               end else begin
                  next_q     = step_q;
                  next_count = amount - ONE;
                  next_state = (amount > ONE) ? ST_BUSY : ST_DONE;
               end
            end else begin
               next_q     = (mode_in == MODE_LOAD) ? d : step_q;
               next_state = ST_IDLE;
            end
         end
      endcase
   end

   // busy/done are registered from next_state so they are glitch-free.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         q          <= '0;
         count      <= '0;
         burst_mode <= MODE_HOLD;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= next_state;
         q          <= next_q;
         count      <= next_count;
         burst_mode <= next_burst_mode;
         busy       <= (next_state == ST_BUSY);
         done       <= (next_state == ST_DONE);
      end
   end

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomized scoreboard bench for universal_shift_register (WIDTH=8, CNT_W=8)
// with directed scenarios and a step-count reference model.
module tb_universal_shift_register;

   localparam int M_HOLD = 0, M_LOAD = 1, M_SHL = 2, M_SHR = 3,
                  M_ROL = 4, M_ROR = 5, M_ASR = 6, M_CLEAR = 7;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] mode;
   logic [7:0] d;
   logic       serial_in;
   logic       start;
   logic [7:0] amount;
   logic [7:0] q;
   logic       serial_out;
   logic       busy;
   logic       done;

   universal_shift_register #(.WIDTH(8), .CNT_W(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .mode       (mode),
      .d          (d),
      .serial_in  (serial_in),
      .start      (start),
      .amount     (amount),
      .q          (q),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int q;
      bit busy;
      bit done;
      bit so;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   // Reference model: register value plus number of burst steps still owed.
   int   mq    = 0;
   int   rem   = 0;
   int   lmode = M_HOLD;
   bit   mdone = 0;

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int ref_step(input int v, input int m, input int dv, input int si);
      case (m)
         M_LOAD:  return dv;
         M_SHL:   return (v * 2 + si) % 256;
         M_SHR:   return v / 2 + si * 128;
         M_ROL:   return (v * 2) % 256 + v / 128;
         M_ROR:   return v / 2 + (v % 2) * 128;
         M_ASR:   return v / 2 + ((v >= 128) ? 128 : 0);
         M_CLEAR: return 0;
         default: return v;
      endcase
   endfunction

   // Drive one cycle of inputs, predict the post-edge outputs, then wait past the edge.
   task automatic tick(input int m, input int dv, input int si, input int st, input int amt);
      exp_t e;
      int   sm;
      mode      = 3'(m);
      d         = 8'(dv);
      serial_in = 1'(si);
      start     = 1'(st);
      amount    = 8'(amt);
      if (rem > 0) begin
         mq    = ref_step(mq, lmode, dv, si);
         rem   = rem - 1;
         mdone = (rem == 0);
      end else if (st != 0 && m >= M_SHL && m <= M_ASR) begin
         lmode = m;
         if (amt == 0) begin
            mdone = 1;
         end else begin
            mq    = ref_step(mq, m, dv, si);
            rem   = amt - 1;
            mdone = (rem == 0);
         end
      end else begin
         mq    = ref_step(mq, m, dv, si);
         mdone = 0;
      end
      sm     = (rem > 0) ? lmode : m;
      e.q    = mq;
      e.busy = (rem > 0);
      e.done = mdone;
      e.so   = (sm == M_SHL || sm == M_ROL) ? ((mq / 128) % 2 == 1) : (mq % 2 == 1);
      sb.push_back(e);
      @(posedge clock);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("reset_q", int'(q), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      mq = 0; rem = 0; mdone = 0; lmode = M_HOLD;
      mode = 3'(M_HOLD); start = 1'b0;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_q", int'(q), e.q);
            check("sb_busy", int'(busy), int'(e.busy));
            check("sb_done", int'(done), int'(e.done));
            check("sb_serial_out", int'(serial_out), int'(e.so));
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int m, st, amt;
      reset = 1'b0; mode = '0; d = '0; serial_in = 1'b0; start = 1'b0; amount = '0;
      #1;
      check("por_q", int'(q), 0);
      check("por_busy", int'(busy), 0);
      check("por_done", int'(done), 0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;

      // LOAD then single ROL
      tick(M_LOAD, 'hA5, 0, 0, 0);
      check("load_q", int'(q), 'hA5);
      tick(M_ROL, 0, 0, 0, 0);
      check("rol_q", int'(q), 'h4B);
      check("rol_busy", int'(busy), 0);
      check("rol_done", int'(done), 0);

      // SHR burst of 3 with serial_in=1
      tick(M_LOAD, 'h80, 0, 0, 0);
      tick(M_SHR, 0, 1, 1, 3);
      check("shr1_q", int'(q), 'hC0);
      check("shr1_busy", int'(busy), 1);
      tick(M_HOLD, 0, 1, 0, 0);
      check("shr2_q", int'(q), 'hE0);
      check("shr2_busy", int'(busy), 1);
      tick(M_HOLD, 0, 1, 0, 0);
      check("shr3_q", int'(q), 'hF0);
      check("shr3_busy", int'(busy), 0);
      check("shr3_done", int'(done), 1);
      tick(M_HOLD, 0, 0, 0, 0);
      check("shr_after_done", int'(done), 0);

      // ASR burst of 2
      tick(M_LOAD, 'h90, 0, 0, 0);
      tick(M_ASR, 0, 0, 1, 2);
      check("asr1_q", int'(q), 'hC8);
      tick(M_HOLD, 0, 0, 0, 0);
      check("asr2_q", int'(q), 'hE4);
      check("asr2_done", int'(done), 1);

      // ROR burst longer than WIDTH, with starts ignored while busy
      tick(M_LOAD, 'h01, 0, 0, 0);
      tick(M_ROR, 0, 0, 1, 9);
      for (int i = 0; i < 7; i++) tick(M_LOAD, 'hFF, 0, 1, 3);
      check("ror_busy", int'(busy), 1);
      tick(M_LOAD, 'hFF, 0, 1, 3);
      check("ror_q", int'(q), 'h80);
      check("ror_done", int'(done), 1);
      tick(M_ROR, 0, 0, 1, 0);
      check("amt0_q", int'(q), 'h80);
      check("amt0_done", int'(done), 1);
      check("amt0_busy", int'(busy), 0);

      // Back-to-back burst started from DONE
      tick(M_SHL, 0, 1, 1, 1);
      check("b2b_done", int'(done), 1);
      tick(M_SHR, 0, 0, 1, 2);
      check("b2b_busy", int'(busy), 1);
      tick(M_HOLD, 0, 0, 0, 0);

      // Reset in the middle of an SHL burst
      tick(M_LOAD, 'h00, 0, 0, 0);
      tick(M_SHL, 0, 1, 1, 5);
      tick(M_HOLD, 0, 1, 0, 0);
      do_reset();
      tick(M_HOLD, 0, 0, 0, 0);
      check("post_reset_done", int'(done), 0);
      tick(M_LOAD, 'h3C, 0, 0, 0);
      check("post_reset_load", int'(q), 'h3C);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         m   = int'($urandom_range(0, 7));
         st  = ($urandom_range(0, 3) == 0) ? 1 : 0;
         amt = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 12));
         if ($urandom_range(0, 399) == 0) do_reset();
         else tick(m, int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), st, amt);
      end

      @(posedge clock);
      #3;
      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
